lcd_gdram_bus_decoder: RTL and testbench

//  LCD-side end of the ST7920-style 8-bit parallel bus (rs/rw/en/data) driven by our LCD block controllers.

---
 rtl/lcd_bus_pkg.sv | 24 ++
 rtl/lcd_bus_sync.sv | 62 ++++++
 rtl/lcd_gdram_bus_decoder.sv | 168 ++++++++++++++++
 tb/tb_lcd_gdram_bus_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared constants and types for the ST7920-style LCD bus decoder.
// Build option LCD_DEC_BUSY_EN (see lcd_gdram_bus_decoder) enables the busy-flag model.
package lcd_bus_pkg;

  localparam logic [7:0] FUNC_SET_PAT  = 8'h20;
  localparam logic [7:0] FUNC_SET_MASK = 8'hE0;
  localparam int         RE_BIT        = 2;
  localparam int         G_BIT         = 1;
  localparam int         ADDR_BIT      = 7;
  localparam int         GDRAM_Y_W     = 5;
  localparam int         GDRAM_X_W     = 4;
  localparam int         WR_ADDR_W     = GDRAM_Y_W + GDRAM_X_W + 1;

  typedef enum logic [1:0] {
    NO_ADDR = 2'd0,
    WAIT_X  = 2'd1,
    ADDR_OK = 2'd2
  } gdram_state_e;

  function automatic logic is_func_set(input logic [7:0] b);
    return (b & FUNC_SET_MASK) == FUNC_SET_PAT;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus into clk and flags the en falling edge.
// rs/rw/data are held from the last synchronized en-high cycle so they line up with the edge.
module lcd_bus_sync
  import lcd_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs_i,
  input  logic       lcd_rw_i,
  input  logic       lcd_en_i,
  input  logic [7:0] lcd_data_i,
  output logic       en_fall_o,
  output logic       en_cur_o,
  output logic       rs_cur_o,
  output logic       rw_cur_o,
  output logic       rs_smp_o,
  output logic       rw_smp_o,
  output logic [7:0] data_smp_o
);

  logic [SYNC_STAGES:0]        en_q;
  logic [SYNC_STAGES-1:0]      rs_q;
  logic [SYNC_STAGES-1:0]      rw_q;
  logic [SYNC_STAGES-1:0][7:0] data_q;
  logic                        rs_hold_q;
  logic                        rw_hold_q;
  logic [7:0]                  data_hold_q;

  // en carries one extra stage so en_q[S] is the previous value of en_q[S-1].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= '0;
      rs_q        <= '0;
      rw_q        <= '0;
      data_q      <= '0;
      rs_hold_q   <= 1'b0;
      rw_hold_q   <= 1'b0;
      data_hold_q <= 8'h00;
    end else begin
      en_q   <= {en_q[SYNC_STAGES-1:0], lcd_en_i};
      rs_q   <= {rs_q[SYNC_STAGES-2:0], lcd_rs_i};
      rw_q   <= {rw_q[SYNC_STAGES-2:0], lcd_rw_i};
      data_q <= {data_q[SYNC_STAGES-2:0], lcd_data_i};
      if (en_q[SYNC_STAGES-1]) begin
        rs_hold_q   <= rs_q[SYNC_STAGES-1];
        rw_hold_q   <= rw_q[SYNC_STAGES-1];
        data_hold_q <= data_q[SYNC_STAGES-1];
      end
    end
  end

  assign en_fall_o  = en_q[SYNC_STAGES] & ~en_q[SYNC_STAGES-1];
  assign en_cur_o   = en_q[SYNC_STAGES-1];
  assign rs_cur_o   = rs_q[SYNC_STAGES-1];
  assign rw_cur_o   = rw_q[SYNC_STAGES-1];
  assign rs_smp_o   = rs_hold_q;
  assign rw_smp_o   = rw_hold_q;
  assign data_smp_o = data_hold_q;

endmodule

// File: rtl/lcd_gdram_bus_decoder.sv
// LCD-side ST7920 bus decoder: instruction decode, GDRAM Y/X addressing, byte writes.
// Define LCD_DEC_BUSY_EN to model the busy flag and read-back of BF.
module lcd_gdram_bus_decoder
  import lcd_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 3600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lcd_rs,
  input  logic                 lcd_rw,
  input  logic                 lcd_en,
  input  logic [7:0]           lcd_data,
  output logic [7:0]           lcd_data_out,
  output logic                 lcd_data_oe,
  output logic                 wr_valid,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic                 ext_mode,
  output logic                 gfx_on,
  output logic                 err_pulse
);

`ifdef LCD_DEC_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

  logic       en_fall, en_cur, rs_cur, rw_cur, rs_smp, rw_smp;
  logic [7:0] d;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .lcd_rs_i   (lcd_rs),
    .lcd_rw_i   (lcd_rw),
    .lcd_en_i   (lcd_en),
    .lcd_data_i (lcd_data),
    .en_fall_o  (en_fall),
    .en_cur_o   (en_cur),
    .rs_cur_o   (rs_cur),
    .rw_cur_o   (rw_cur),
    .rs_smp_o   (rs_smp),
    .rw_smp_o   (rw_smp),
    .data_smp_o (d)
  );

  gdram_state_e               state_q, state_d;
  logic [GDRAM_Y_W-1:0]       y_q, y_d;
  logic [GDRAM_X_W-1:0]       x_q, x_d;
  logic                       bsel_q, bsel_d;
  logic [CNT_W-1:0]           busy_q, busy_d;
  logic                       bf;
  logic                       wr_vld_q, wr_vld_d, cmd_vld_q, cmd_vld_d, err_q, err_d;
  logic [WR_ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]                 wr_data_q, wr_data_d, cmd_code_q, cmd_code_d;
  logic                       ext_q, ext_d, gfx_q, gfx_d;
  logic                       oe_q, oe_d;
  logic [7:0]                 dout_q, dout_d;

  assign bf = (busy_q != '0);

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    x_d        = x_q;
    bsel_d     = bsel_q;
    busy_d     = bf ? busy_q - CNT_W'(1) : '0;
    wr_vld_d   = 1'b0;
    cmd_vld_d  = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cmd_code_d = cmd_code_q;
    ext_d      = ext_q;
    gfx_d      = gfx_q;
    oe_d       = BUSY_EN & en_cur & ~rs_cur & rw_cur;
    dout_d     = oe_d ? {bf, 7'b0} : 8'h00;

    if (en_fall && !rw_smp) begin
      // A write accepted while busy still decodes, but is flagged.
      if (BUSY_EN) begin
        if (bf) err_d = 1'b1;
        busy_d = CNT_W'(BUSY_CYCLES);
      end
      if (!rs_smp) begin
        if (is_func_set(d)) begin
          ext_d = d[RE_BIT];
          if (d[RE_BIT]) gfx_d = d[G_BIT];
          else           state_d = NO_ADDR;
        end else if (ext_q && d[ADDR_BIT]) begin
          if (state_q == WAIT_X) begin
            x_d     = d[GDRAM_X_W-1:0];
            bsel_d  = 1'b0;
            state_d = ADDR_OK;
          end else begin
            y_d     = d[GDRAM_Y_W-1:0];
            state_d = WAIT_X;
          end
        end else if (!ext_q) begin
          cmd_vld_d  = 1'b1;
          cmd_code_d = d;
        end
      end else if (state_q == ADDR_OK) begin
        wr_vld_d  = 1'b1;
        wr_addr_d = {y_q, x_q, bsel_q};
        wr_data_d = d;
        bsel_d    = ~bsel_q;
        if (bsel_q) x_d = x_q + GDRAM_X_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NO_ADDR;
      y_q        <= '0;
      x_q        <= '0;
      bsel_q     <= 1'b0;
      busy_q     <= '0;
      wr_vld_q   <= 1'b0;
      cmd_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      cmd_code_q <= 8'h00;
      ext_q      <= 1'b0;
      gfx_q      <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      x_q        <= x_d;
      bsel_q     <= bsel_d;
      busy_q     <= busy_d;
      wr_vld_q   <= wr_vld_d;
      cmd_vld_q  <= cmd_vld_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cmd_code_q <= cmd_code_d;
      ext_q      <= ext_d;
      gfx_q      <= gfx_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
    end
  end

  assign wr_valid     = wr_vld_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cmd_valid    = cmd_vld_q;
  assign cmd_code     = cmd_code_q;
  assign err_pulse    = err_q;
  assign ext_mode     = ext_q;
  assign gfx_on       = gfx_q;
  assign lcd_data_oe  = oe_q;
  assign lcd_data_out = dout_q;

endmodule

// File: tb/tb_lcd_gdram_bus_decoder.sv
// Scoreboard bench for lcd_gdram_bus_decoder: expected writes/commands/errors are queued by the driver.
module tb_lcd_gdram_bus_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe, wr_valid, cmd_valid, ext_mode, gfx_on, err_pulse;
  logic [9:0] wr_addr;
  logic [7:0] wr_data, cmd_code;

  lcd_gdram_bus_decoder dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .ext_mode(ext_mode),
    .gfx_on(gfx_on), .err_pulse(err_pulse)
  );

  always #10 clk = ~clk;

`ifdef LCD_DEC_BUSY_EN
  localparam bit BUSY = 1'b1;
`else
  localparam bit BUSY = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      last_wr = -100000;
  logic [17:0] wr_q[$];
  logic [7:0]  cmd_q[$];
  bit          err_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got pulse expected none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        if (wr_q.size() == 0) unexpected("wr_valid");
        else check("wr_addr_data", {14'd0, wr_addr, wr_data}, {14'd0, wr_q.pop_front()});
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) unexpected("cmd_valid");
        else check("cmd_code", {24'd0, cmd_code}, {24'd0, cmd_q.pop_front()});
      end
      if (err_pulse) begin
        if (err_q.size() == 0) unexpected("err_pulse");
        else void'(err_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_wr = -100000;
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    repeat (2) @(negedge clk);
    lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Write with optional expected data error; busy model adds one BF error if still busy.
  task automatic bus_write(input logic rs, input logic [7:0] d, input bit exp_err);
    bit busy;
    busy = BUSY && ((cyc - last_wr) < 3000);
    if (exp_err || busy) err_q.push_back(1'b1);
    last_wr = cyc;
    bus_cycle(rs, 1'b0, d);
  endtask

  task automatic wr_data_exp(input logic [7:0] d, input logic [9:0] addr);
    wr_q.push_back({addr, d});
    bus_write(1'b1, d, 1'b0);
  endtask

  task automatic cmd_exp(input logic [7:0] d);
    cmd_q.push_back(d);
    bus_write(1'b0, d, 1'b0);
  endtask

  task automatic bus_read(output logic oe, output logic [7:0] dout);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_data = 8'h00;
    repeat (2) @(negedge clk);
    lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    oe = lcd_data_oe;
    dout = lcd_data_out;
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  logic       rd_oe;
  logic [7:0] rd_val;
  logic [8:0] exp_rd_busy, exp_rd_idle;

  initial begin
`ifdef LCD_DEC_BUSY_EN
    exp_rd_busy = 9'h180;
    exp_rd_idle = 9'h100;
`else
    exp_rd_busy = 9'h000;
    exp_rd_idle = 9'h000;
`endif
    do_reset();
    @(negedge clk);
    check("reset_outputs",
          {6'd0, wr_valid, wr_addr, wr_data, cmd_valid, cmd_code},
          32'd0);
    check("reset_flags", {26'd0, ext_mode, gfx_on, err_pulse, lcd_data_oe, 2'b00},
          32'd0);
    check("reset_rdata", {24'd0, lcd_data_out}, 32'd0);

    // Data with no address after reset: error, no write.
    bus_write(1'b1, 8'h11, 1'b1);

    // Basic example: function sets, Y=0, X=0, two bytes.
    bus_write(1'b0, 8'h30, 1'b0);
    bus_write(1'b0, 8'h36, 1'b0);
    drain();
    check("ext_mode_on", {31'd0, ext_mode}, 32'd1);
    check("gfx_on_set", {31'd0, gfx_on}, 32'd1);
    bus_write(1'b0, 8'h80, 1'b0);
    bus_write(1'b0, 8'h80, 1'b0);
    wr_data_exp(8'hFF, 10'h000);
    wr_data_exp(8'h00, 10'h001);

    // Non-address extended instruction is ignored.
    bus_write(1'b0, 8'h03, 1'b0);

    // Y=31, X=15: x wraps to 0, y held.
    bus_write(1'b0, 8'h9F, 1'b0);
    bus_write(1'b0, 8'h8F, 1'b0);
    wr_data_exp(8'hA1, 10'h3FE);
    wr_data_exp(8'hA2, 10'h3FF);
    wr_data_exp(8'hA3, 10'h3E0);
    wr_data_exp(8'hA4, 10'h3E1);

    // Leave extended mode: gfx held, basic commands emitted, GDRAM address dropped.
    bus_write(1'b0, 8'h30, 1'b0);
    drain();
    check("ext_mode_off", {31'd0, ext_mode}, 32'd0);
    check("gfx_on_held", {31'd0, gfx_on}, 32'd1);
    cmd_exp(8'h0C);
    cmd_exp(8'h01);
    cmd_exp(8'h80);
    bus_write(1'b1, 8'h22, 1'b1);

    // Read cycles never change state; BF read-back depends on build.
    bus_cycle(1'b1, 1'b1, 8'h55);
    while ((cyc - last_wr) < 500) @(negedge clk);
    bus_read(rd_oe, rd_val);
    check("read_busy", {23'd0, rd_oe, rd_val}, {23'd0, exp_rd_busy});
    while ((cyc - last_wr) < 4000) @(negedge clk);
    bus_read(rd_oe, rd_val);
    check("read_idle", {23'd0, rd_oe, rd_val}, {23'd0, exp_rd_idle});

    // Reset between Y-set and X-set: the address restarts from NO_ADDR.
    bus_write(1'b0, 8'h36, 1'b0);
    bus_write(1'b0, 8'h85, 1'b0);
    drain();
    do_reset();
    @(negedge clk);
    check("rst_ext_clear", {30'd0, ext_mode, gfx_on}, 32'd0);
    bus_write(1'b0, 8'h36, 1'b0);
    bus_write(1'b0, 8'h80, 1'b0);
    bus_write(1'b1, 8'h33, 1'b1);
    bus_write(1'b0, 8'h82, 1'b0);
    wr_data_exp(8'h5A, 10'h004);

    drain();
    check("wr_q_drained", wr_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
